// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle RV32I integer/branch execution stage.
//
// Takes one ready-operand instruction per cycle from the reservation station,
// computes its result combinationally and writes it into a small result FIFO on
// the same edge. The oldest entry is offered on the common data bus until the
// CDB arbiter grants it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global enable; low freezes all state
//   flush               synchronous clear of all buffered results
//   *_from_rs           issued instruction (valid, optype, pc, Vi, Vj, imm, tag)
//   alu_full            FIFO full; the RS must not issue
//   cdb_req/cdb_grant   head-entry broadcast handshake
//   cdb_tag/val/jump/target  head entry contents
module alu_exec_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned OP_W       = 6,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              valid_from_rs,
    input  logic [OP_W-1:0]   optype_from_rs,
    input  logic [DATA_W-1:0] pc_from_rs,
    input  logic [DATA_W-1:0] Vi_from_rs,
    input  logic [DATA_W-1:0] Vj_from_rs,
    input  logic [DATA_W-1:0] imm_from_rs,
    input  logic [TAG_W-1:0]  tag_from_rs,
    output logic              alu_full,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_val,
    output logic              cdb_jump,
    output logic [DATA_W-1:0] cdb_target
);

    // Shared RV32I optype encodings; 0 and anything unlisted is treated as unknown.
    localparam logic [OP_W-1:0] OpAdd   = OP_W'(1);
    localparam logic [OP_W-1:0] OpSub   = OP_W'(2);
    localparam logic [OP_W-1:0] OpSll   = OP_W'(3);
    localparam logic [OP_W-1:0] OpSlt   = OP_W'(4);
    localparam logic [OP_W-1:0] OpSltu  = OP_W'(5);
    localparam logic [OP_W-1:0] OpXor   = OP_W'(6);
    localparam logic [OP_W-1:0] OpSrl   = OP_W'(7);
    localparam logic [OP_W-1:0] OpSra   = OP_W'(8);
    localparam logic [OP_W-1:0] OpOr    = OP_W'(9);
    localparam logic [OP_W-1:0] OpAnd   = OP_W'(10);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'(11);
    localparam logic [OP_W-1:0] OpSlti  = OP_W'(12);
    localparam logic [OP_W-1:0] OpSltiu = OP_W'(13);
    localparam logic [OP_W-1:0] OpXori  = OP_W'(14);
    localparam logic [OP_W-1:0] OpOri   = OP_W'(15);
    localparam logic [OP_W-1:0] OpAndi  = OP_W'(16);
    localparam logic [OP_W-1:0] OpSlli  = OP_W'(17);
    localparam logic [OP_W-1:0] OpSrli  = OP_W'(18);
    localparam logic [OP_W-1:0] OpSrai  = OP_W'(19);
    localparam logic [OP_W-1:0] OpLui   = OP_W'(20);
    localparam logic [OP_W-1:0] OpAuipc = OP_W'(21);
    localparam logic [OP_W-1:0] OpJal   = OP_W'(22);
    localparam logic [OP_W-1:0] OpJalr  = OP_W'(23);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'(24);
    localparam logic [OP_W-1:0] OpBne   = OP_W'(25);
    localparam logic [OP_W-1:0] OpBlt   = OP_W'(26);
    localparam logic [OP_W-1:0] OpBge   = OP_W'(27);
    localparam logic [OP_W-1:0] OpBltu  = OP_W'(28);
    localparam logic [OP_W-1:0] OpBgeu  = OP_W'(29);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic              jump;
        logic [DATA_W-1:0] target;
    } entry_t;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- compute
    logic              is_imm;
    logic [DATA_W-1:0] op2;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic              taken;
    entry_t            new_e;

    always_comb begin
        is_imm = (optype_from_rs inside {OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi,
                                         OpSlli, OpSrli, OpSrai});
        op2         = is_imm ? imm_from_rs : Vj_from_rs;
        shamt       = op2[4:0];
        pc_plus4    = pc_from_rs + DATA_W'(4);
        pc_plus_imm = pc_from_rs + imm_from_rs;
        taken       = 1'b0;

        new_e.tag    = tag_from_rs;
        new_e.val    = '0;
        new_e.jump   = 1'b0;
        new_e.target = pc_plus4;

        case (optype_from_rs)
            OpAdd, OpAddi:   new_e.val = Vi_from_rs + op2;
            OpSub:           new_e.val = Vi_from_rs - Vj_from_rs;
            OpSlt, OpSlti:   new_e.val = DATA_W'($signed(Vi_from_rs) < $signed(op2));
            OpSltu, OpSltiu: new_e.val = DATA_W'(Vi_from_rs < op2);
            OpSll, OpSlli:   new_e.val = Vi_from_rs << shamt;
            OpSrl, OpSrli:   new_e.val = Vi_from_rs >> shamt;
            OpSra, OpSrai:   new_e.val = DATA_W'($signed(Vi_from_rs) >>> shamt);
            OpXor, OpXori:   new_e.val = Vi_from_rs ^ op2;
            OpOr, OpOri:     new_e.val = Vi_from_rs | op2;
            OpAnd, OpAndi:   new_e.val = Vi_from_rs & op2;
            OpLui:           new_e.val = imm_from_rs;
            OpAuipc:         new_e.val = pc_plus_imm;
            OpJal: begin
                new_e.val    = pc_plus4;
                new_e.jump   = 1'b1;
                new_e.target = pc_plus_imm;
            end
            OpJalr: begin
                new_e.val    = pc_plus4;
                new_e.jump   = 1'b1;
                new_e.target = (Vi_from_rs + imm_from_rs) & ~DATA_W'(1);
            end
            OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: begin
                case (optype_from_rs)
                    OpBeq:   taken = (Vi_from_rs == Vj_from_rs);
                    OpBne:   taken = (Vi_from_rs != Vj_from_rs);
                    OpBlt:   taken = ($signed(Vi_from_rs) < $signed(Vj_from_rs));
                    OpBge:   taken = ($signed(Vi_from_rs) >= $signed(Vj_from_rs));
                    OpBltu:  taken = (Vi_from_rs < Vj_from_rs);
                    default: taken = (Vi_from_rs >= Vj_from_rs);
                endcase
                new_e.jump   = taken;
                new_e.target = taken ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- result FIFO
    entry_t          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    entry_t          last_q;
    entry_t          head_e;
    logic            push, pop;

    assign alu_full = (count_q == CntW'(FIFO_DEPTH));
    assign cdb_req  = (count_q != '0);
    assign push     = valid_from_rs && !alu_full && rdy && !flush;
    assign pop      = cdb_req && cdb_grant && rdy && !flush;

    // With the FIFO empty the CDB data lines keep showing the last entry offered.
    assign head_e     = cdb_req ? mem_q[head_q] : last_q;
    assign cdb_tag    = head_e.tag;
    assign cdb_val    = head_e.val;
    assign cdb_jump   = head_e.jump;
    assign cdb_target = head_e.target;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= head_e;
            if (push) mem_q[tail_q] <= new_e;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed bench with a result scoreboard for alu_exec_unit.
// Expected results are hand-computed constants pushed when an instruction is
// issued and compared against the CDB head while it is being offered.
module tb_alu_exec_unit;

    localparam logic [5:0] OpAdd = 6'd1, OpSub = 6'd2, OpSll = 6'd3, OpSlt = 6'd4,
                           OpSltu = 6'd5, OpXor = 6'd6, OpSra = 6'd8, OpOr = 6'd9,
                           OpAnd = 6'd10, OpAddi = 6'd11, OpXori = 6'd14, OpSlli = 6'd17,
                           OpLui = 6'd20, OpAuipc = 6'd21, OpJal = 6'd22, OpJalr = 6'd23,
                           OpBeq = 6'd24, OpBlt = 6'd26, OpBgeu = 6'd29, OpBad = 6'd63;
    localparam int Depth = 2;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        jump;
        logic [31:0] target;
    } exp_t;

    logic        clk, rst, rdy, flush, valid_from_rs, cdb_grant;
    logic [5:0]  optype_from_rs;
    logic [31:0] pc_from_rs, Vi_from_rs, Vj_from_rs, imm_from_rs;
    logic [3:0]  tag_from_rs;
    logic        alu_full, cdb_req, cdb_jump;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_target;

    exp_t q[$];
    exp_t pend;
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;

    alu_exec_unit #(
        .DATA_W(32), .TAG_W(4), .OP_W(6), .FIFO_DEPTH(Depth)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .valid_from_rs(valid_from_rs), .optype_from_rs(optype_from_rs),
        .pc_from_rs(pc_from_rs), .Vi_from_rs(Vi_from_rs), .Vj_from_rs(Vj_from_rs),
        .imm_from_rs(imm_from_rs), .tag_from_rs(tag_from_rs),
        .alu_full(alu_full), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_target(cdb_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
        end
    endtask

    task automatic chk_head(input string name, input exp_t e);
        chk({name, ".tag"}, 32'(cdb_tag), 32'(e.tag));
        chk({name, ".val"}, cdb_val, e.val);
        chk({name, ".jump"}, 32'(cdb_jump), 32'(e.jump));
        chk({name, ".target"}, cdb_target, e.target);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] vi,
                         input logic [31:0] vj, input logic [31:0] imm, input logic [3:0] tag,
                         input logic [31:0] ev, input logic ej, input logic [31:0] et);
        valid_from_rs  = 1'b1;
        optype_from_rs = op;
        pc_from_rs     = pc;
        Vi_from_rs     = vi;
        Vj_from_rs     = vj;
        imm_from_rs    = imm;
        tag_from_rs    = tag;
        pend           = '{tag: tag, val: ev, jump: ej, target: et};
    endtask

    // Called at a negedge with this cycle's inputs applied: checks the DUT against
    // the scoreboard, updates the scoreboard for the coming edge, then advances.
    task automatic tick(input string name);
        bit do_pop, do_push;
        chk({name, ".req"}, 32'(cdb_req), 32'(q.size() != 0));
        chk({name, ".full"}, 32'(alu_full), 32'(q.size() == Depth));
        chk({name, ".no_issue_when_full"}, 32'(valid_from_rs && alu_full && rdy), 32'd0);
        if (q.size() != 0) begin
            chk_head({name, ".head"}, q[0]);
            last_exp = q[0];
        end else begin
            chk_head({name, ".hold"}, last_exp);
        end
        do_pop  = (q.size() != 0) && cdb_grant && rdy && !flush;
        do_push = valid_from_rs && rdy && !flush && (q.size() != Depth);
        if (rdy && flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(pend);
        end
        @(posedge clk);
        @(negedge clk);
        valid_from_rs = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; valid_from_rs = 1'b0; cdb_grant = 1'b0;
        optype_from_rs = '0; pc_from_rs = '0; Vi_from_rs = '0; Vj_from_rs = '0;
        imm_from_rs = '0; tag_from_rs = '0;
        last_exp = '0;
        pend = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick("reset");

        // Back-to-back issue with grant held: each result is popped the cycle after issue.
        cdb_grant = 1'b1;
        drive(OpAddi, 32'h0, 32'd5, 32'h0, 32'hFFFF_FFFD, 4'd7, 32'd2, 1'b0, 32'h4);
        tick("addi");
        drive(OpSra, 32'h10, 32'h8000_0000, 32'h24, 32'h0, 4'd1, 32'hF800_0000, 1'b0, 32'h14);
        tick("sra");
        drive(OpSltu, 32'h14, 32'd1, 32'hFFFF_FFFF, 32'h0, 4'd2, 32'd1, 1'b0, 32'h18);
        tick("sltu");
        drive(OpBlt, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h20, 4'd3, 32'd0, 1'b1, 32'h120);
        tick("blt");
        drive(OpJalr, 32'h40, 32'h203, 32'h0, 32'h0, 4'd4, 32'h44, 1'b1, 32'h202);
        tick("jalr");
        drive(OpBeq, 32'h200, 32'd1, 32'd2, 32'h40, 4'd5, 32'd0, 1'b0, 32'h204);
        tick("beq_nt");
        drive(OpSub, 32'h0, 32'd3, 32'd5, 32'h0, 4'd6, 32'hFFFF_FFFE, 1'b0, 32'h4);
        tick("sub");
        drive(OpLui, 32'h8, 32'h0, 32'h0, 32'h1234_5000, 4'd8, 32'h1234_5000, 1'b0, 32'hC);
        tick("lui");
        drive(OpAuipc, 32'h1000, 32'h0, 32'h0, 32'h2000, 4'd9, 32'h3000, 1'b0, 32'h1004);
        tick("auipc");
        drive(OpJal, 32'h80, 32'h0, 32'h0, 32'hFFFF_FFF8, 4'd10, 32'h84, 1'b1, 32'h78);
        tick("jal");
        drive(OpBgeu, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 4'd11, 32'd0, 1'b1, 32'h310);
        tick("bgeu");
        drive(OpBad, 32'h50, 32'h7, 32'h9, 32'h4, 4'd12, 32'd0, 1'b0, 32'h54);
        tick("unknown");
        drive(OpSlli, 32'h0, 32'd1, 32'h0, 32'd31, 4'd13, 32'h8000_0000, 1'b0, 32'h4);
        tick("slli");
        drive(OpSlt, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'd14, 32'd1, 1'b0, 32'h4);
        tick("slt");
        drive(OpXori, 32'h0, 32'h0000_F0F0, 32'h0, 32'hFF, 4'd15, 32'h0000_F00F, 1'b0, 32'h4);
        tick("xori");
        tick("drain");

        // Backpressure: two issues without grant fill the FIFO; head must hold steady.
        cdb_grant = 1'b0;
        drive(OpAdd, 32'h0, 32'd10, 32'd20, 32'h0, 4'd8, 32'd30, 1'b0, 32'h4);
        tick("bp_a");
        drive(OpOr, 32'h0, 32'hF0, 32'h0F, 32'h0, 4'd9, 32'hFF, 1'b0, 32'h4);
        tick("bp_b");
        tick("bp_full1");
        tick("bp_full2");
        cdb_grant = 1'b1;
        tick("bp_pop");
        // Push and pop together keep one entry, order preserved.
        drive(OpXor, 32'h0, 32'hFF, 32'h0F, 32'h0, 4'd10, 32'hF0, 1'b0, 32'h4);
        tick("push_pop");
        cdb_grant = 1'b0;
        tick("after_push_pop");

        // Flush with two entries pending; also overrides a simultaneous issue.
        drive(OpAnd, 32'h0, 32'hFF, 32'h0F, 32'h0, 4'd11, 32'h0F, 1'b0, 32'h4);
        tick("fill2");
        flush = 1'b1;
        cdb_grant = 1'b1;
        tick("flush");
        flush = 1'b0;
        cdb_grant = 1'b0;
        tick("post_flush");

        // Pause: rdy low with valid and grant asserted changes nothing.
        drive(OpSll, 32'h0, 32'd1, 32'd4, 32'h0, 4'd12, 32'd16, 1'b0, 32'h4);
        tick("pause_fill");
        rdy = 1'b0;
        cdb_grant = 1'b1;
        drive(OpAdd, 32'h0, 32'd1, 32'd1, 32'h0, 4'd13, 32'd2, 1'b0, 32'h4);
        tick("pause1");
        tick("pause2");
        rdy = 1'b1;
        cdb_grant = 1'b0;
        tick("resume");

        // Asynchronous reset between edges with one entry pending.
        #2 rst = 1'b1;
        #1;
        chk("async_rst.req", 32'(cdb_req), 32'd0);
        chk("async_rst.full", 32'(alu_full), 32'd0);
        chk("async_rst.tag", 32'(cdb_tag), 32'd0);
        chk("async_rst.val", cdb_val, 32'd0);
        q.delete();
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        tick("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
